// File: rtl/demux3w_1to8_pkg.sv
// ----------------------------------------------------------------------------
// demux3w_1to8_pkg
//
// Purpose : Shared lab constants and types for the 3-bit, 1-to-8 time-division
//           demultiplexer. Lane width, slot count and the derived slot-index
//           width live here so the decoder and the top agree on them.
//
// Contents: WIDTH      - lane / sample width in bits
//           NUM_SLOTS  - samples per frame
//           SLOT_BITS  - width of the slot counter
//           LAST_SLOT  - index of the slot that completes a frame
//           sample_t   - one sample / lane word
//           slot_t     - slot counter word
//           action_e   - what the current edge does to the frame
//           nextSlot() - wrapping slot increment
// ----------------------------------------------------------------------------
package demux3w_1to8_pkg;

    localparam int WIDTH     = 3;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_BITS = $clog2(NUM_SLOTS);
    localparam int LAST_SLOT = NUM_SLOTS - 1;

    typedef logic [WIDTH-1:0]     sample_t;
    typedef logic [SLOT_BITS-1:0] slot_t;

    // Classification of a single clock edge. RESYNC covers Sync with or
    // without a sample; COMPLETE is an accepted sample landing in the last
    // slot without Sync, which is the only case that updates the lanes.
    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_STORE    = 2'd1,
        ACT_COMPLETE = 2'd2,
        ACT_RESYNC   = 2'd3
    } action_e;

    // Advance the slot index, wrapping from the last slot back to 0.
    function automatic slot_t nextSlot(input slot_t s);
        if (s == slot_t'(LAST_SLOT)) begin
            return '0;
        end
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/demux3w_1to8_decoder.sv
// ----------------------------------------------------------------------------
// Decoder3to8
//
// Purpose : Turns the slot index into a one-hot write enable for the staging
//           registers. All enables are low when no sample is offered, so the
//           top never has to gate the enables again.
//
// Ports   : slot_i   in  SLOT_BITS  slot that the offered sample belongs to
//           valid_i  in  1          a sample is offered this cycle
//           we_o     out NUM_SLOTS  one-hot write enable (all zero if !valid_i)
// ----------------------------------------------------------------------------
module Decoder3to8
    import demux3w_1to8_pkg::*;
(
    input  logic [SLOT_BITS-1:0] slot_i,
    input  logic                 valid_i,
    output logic [NUM_SLOTS-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (valid_i) begin
            we_o[slot_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux3w_1to8.sv
// ----------------------------------------------------------------------------
// demux3w_1to8
//
// Purpose : Collects a time-division stream of 3-bit samples into frames of
//           eight slots and presents each complete frame on eight registered
//           lanes R..Y. Sync realigns the stream to slot 0; a Sync that cuts
//           a frame short raises a sticky SyncErr.
//
// Ports   : Clock      in   1  rising-edge clock
//           Resetn     in   1  asynchronous active-low reset
//           D          in   3  sample word
//           Valid      in   1  D carries a sample this cycle
//           Sync       in   1  this cycle starts a new frame at slot 0
//           R..Y       out  3  frame lanes 0..7, registered
//           Slot       out  3  slot the next accepted sample fills
//           FrameDone  out  1  one-cycle pulse after the lanes update
//           SyncErr    out  1  sticky short-frame flag
// ----------------------------------------------------------------------------
module demux3w_1to8
    import demux3w_1to8_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] D,
    input  logic             Valid,
    input  logic             Sync,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] U,
    output logic [WIDTH-1:0] V,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [SLOT_BITS-1:0] Slot,
    output logic             FrameDone,
    output logic             SyncErr
);

    // The last slot is never staged: its sample goes straight into lane Y on
    // the completing edge, so only slots 0..LAST_SLOT-1 need storage.
    sample_t stage_q [LAST_SLOT];
    sample_t stage_d [LAST_SLOT];
    sample_t lanes_q [NUM_SLOTS];
    sample_t lanes_d [NUM_SLOTS];

    slot_t   slot_q,      slot_d;
    logic    frameDone_q, frameDone_d;
    logic    syncErr_q,   syncErr_d;

    slot_t                 writeSlot;
    logic [NUM_SLOTS-1:0]  writeEn;
    action_e               action;

    // Sync forces the incoming sample into slot 0 regardless of the counter,
    // which also keeps the last-slot enable low so a Sync never completes a
    // frame.
    assign writeSlot = Sync ? '0 : slot_q;

    Decoder3to8 u_decoder (
        .slot_i  (writeSlot),
        .valid_i (Valid),
        .we_o    (writeEn)
    );

    // Classify the edge. Sync outranks everything, including a sample that
    // would otherwise have finished the frame.
    always_comb begin
        action = ACT_HOLD;
        if (Sync) begin
            action = ACT_RESYNC;
        end else if (writeEn[LAST_SLOT]) begin
            action = ACT_COMPLETE;
        end else if (Valid) begin
            action = ACT_STORE;
        end
    end

    // Counter, flags and lanes next state.
    always_comb begin
        slot_d      = slot_q;
        frameDone_d = 1'b0;
        syncErr_d   = syncErr_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            lanes_d[i] = lanes_q[i];
        end

        unique case (action)
            ACT_RESYNC: begin
                // A sample arriving with Sync already occupies slot 0.
                slot_d = Valid ? slot_t'(1) : slot_t'(0);
                if (slot_q != '0) begin
                    syncErr_d = 1'b1;
                end
            end
            ACT_STORE: begin
                slot_d = nextSlot(slot_q);
            end
            ACT_COMPLETE: begin
                slot_d      = nextSlot(slot_q);
                frameDone_d = 1'b1;
                for (int i = 0; i < LAST_SLOT; i++) begin
                    lanes_d[i] = stage_q[i];
                end
                lanes_d[LAST_SLOT] = D;
            end
            default: begin
            end
        endcase
    end

    // Staging next state: each register takes D only when its enable fires.
    always_comb begin
        for (int i = 0; i < LAST_SLOT; i++) begin
            stage_d[i] = writeEn[i] ? D : stage_q[i];
        end
    end

    // All state, cleared asynchronously so a reset mid-frame discards the
    // partial frame and blanks the lanes immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            slot_q      <= '0;
            frameDone_q <= 1'b0;
            syncErr_q   <= 1'b0;
            for (int i = 0; i < LAST_SLOT; i++) begin
                stage_q[i] <= '0;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            frameDone_q <= frameDone_d;
            syncErr_q   <= syncErr_d;
            for (int i = 0; i < LAST_SLOT; i++) begin
                stage_q[i] <= stage_d[i];
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lanes_q[i] <= lanes_d[i];
            end
        end
    end

    assign R = lanes_q[0];
    assign S = lanes_q[1];
    assign T = lanes_q[2];
    assign U = lanes_q[3];
    assign V = lanes_q[4];
    assign W = lanes_q[5];
    assign X = lanes_q[6];
    assign Y = lanes_q[7];

    assign Slot      = slot_q;
    assign FrameDone = frameDone_q;
    assign SyncErr   = syncErr_q;

endmodule

// File: tb/tb_demux3w_1to8.sv
// ----------------------------------------------------------------------------
// tb_demux3w_1to8
//
// Purpose : Directed self-checking bench for demux3w_1to8. Each driven cycle
//           runs a reference model, pushes the expected post-edge outputs to
//           a scoreboard queue and pops/compares them just after the edge.
//           Extra directed checks compare lanes against known frame patterns.
// ----------------------------------------------------------------------------
module tb_demux3w_1to8;

    logic       Clock;
    logic       Resetn;
    logic [2:0] D;
    logic       Valid;
    logic       Sync;
    logic [2:0] R, S, T, U, V, W, X, Y;
    logic [2:0] Slot;
    logic       FrameDone;
    logic       SyncErr;

    typedef struct packed {
        logic [23:0] lanes;
        logic [2:0]  slot;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   doneCycles[$];

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    logic [2:0] mStage [8];
    logic [2:0] mLanes [8];
    logic [2:0] mSlot;
    logic       mDone;
    logic       mErr;

    demux3w_1to8 dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .D         (D),
        .Valid     (Valid),
        .Sync      (Sync),
        .R         (R),
        .S         (S),
        .T         (T),
        .U         (U),
        .V         (V),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Slot      (Slot),
        .FrameDone (FrameDone),
        .SyncErr   (SyncErr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [23:0] dutLanes();
        return {R, S, T, U, V, W, X, Y};
    endfunction

    function automatic logic [23:0] modelLanes();
        logic [23:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[23 - 3*i -: 3] = mLanes[i];
        end
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mStage[i] = '0;
            mLanes[i] = '0;
        end
        mSlot = '0;
        mDone = 1'b0;
        mErr  = 1'b0;
    endtask

    task automatic modelEdge(input logic v, input logic s, input logic [2:0] d);
        mDone = 1'b0;
        if (s) begin
            if (mSlot != 3'd0) mErr = 1'b1;
            if (v) begin
                mStage[0] = d;
                mSlot     = 3'd1;
            end else begin
                mSlot = 3'd0;
            end
        end else if (v) begin
            mStage[mSlot] = d;
            if (mSlot == 3'd7) begin
                for (int i = 0; i < 8; i++) mLanes[i] = mStage[i];
                mDone = 1'b1;
            end
            mSlot = mSlot + 3'd1;
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.lanes = modelLanes();
        e.slot  = mSlot;
        e.done  = mDone;
        e.err   = mErr;
        sb.push_back(e);
    endtask

    task automatic checkVal(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkVal({tag, "_lanes"}, dutLanes(), e.lanes);
            checkVal({tag, "_slot"},  24'(Slot),      24'(e.slot));
            checkVal({tag, "_done"},  24'(FrameDone), 24'(e.done));
            checkVal({tag, "_err"},   24'(SyncErr),   24'(e.err));
        end
    endtask

    // One clock of stimulus: drive at the falling edge, model the rising
    // edge, then compare just after it.
    task automatic applyStimulus(input logic v, input logic s, input logic [2:0] d, input string tag);
        @(negedge Clock);
        Valid = v;
        Sync  = s;
        D     = d;
        @(posedge Clock);
        modelEdge(v, s, d);
        pushExpected();
        #1;
        cycleCount++;
        if (FrameDone === 1'b1) doneCycles.push_back(cycleCount);
        checkOutput(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear while
    // Resetn is still low.
    task automatic pulseReset(input string tag);
        @(negedge Clock);
        Valid = 1'b0;
        Sync  = 1'b0;
        D     = '0;
        #1 Resetn = 1'b0;
        #1;
        modelReset();
        pushExpected();
        checkOutput(tag);
        checkVal({tag, "_lanes_zero"}, dutLanes(), 24'h0);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        Valid  = 1'b0;
        Sync   = 1'b0;
        D      = '0;
        modelReset();

        #3;
        pushExpected();
        checkOutput("reset");
        @(negedge Clock);
        Resetn = 1'b1;

        // Full frame 0..7
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 3'(i), "full");
        checkVal("full_lanes_pattern", dutLanes(), 24'o01234567);
        checkVal("full_done", 24'(FrameDone), 24'd1);
        checkVal("full_slot", 24'(Slot), 24'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, "full_idle");

        // Same frame with gaps
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 3'(i), "gap_valid");
            if (i != 7) applyStimulus(1'b0, 1'b0, 3'd5, "gap_idle");
        end
        checkVal("gap_lanes_pattern", dutLanes(), 24'o01234567);

        // Short frame aborted by Sync+Valid
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'd5, "short");
        applyStimulus(1'b1, 1'b1, 3'd2, "short_sync");
        checkVal("short_err", 24'(SyncErr), 24'd1);
        checkVal("short_slot", 24'(Slot), 24'd1);
        checkVal("short_nodone", 24'(FrameDone), 24'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 3'((3 + i) % 8), "short_fill");
        checkVal("short_lanes_pattern", dutLanes(), 24'o23456701);

        // Back-to-back frames
        pulseReset("rst_b2b");
        doneCycles.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 3'(i % 8), "b2b");
            if (i == 7) checkVal("b2b_first_pattern", dutLanes(), 24'o01234567);
        end
        checkVal("b2b_second_pattern", dutLanes(), 24'o01234567);
        checkVal("b2b_pulse_count", 24'(doneCycles.size()), 24'd2);
        if (doneCycles.size() == 2) begin
            checkVal("b2b_spacing", 24'(doneCycles[1] - doneCycles[0]), 24'd8);
        end

        // Reset mid-frame
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 3'd1, "mid");
        pulseReset("rst_mid");
        checkVal("mid_slot_zero", 24'(Slot), 24'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 3'(7 - i), "mid_fill");
        checkVal("mid_lanes_pattern", dutLanes(), 24'o76543210);

        // Sync colliding with the slot-7 sample
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 3'd2, "s7");
        checkVal("s7_slot_before", 24'(Slot), 24'd7);
        applyStimulus(1'b1, 1'b1, 3'd6, "s7_sync");
        checkVal("s7_nodone", 24'(FrameDone), 24'd0);
        checkVal("s7_lanes_held", dutLanes(), 24'o76543210);
        checkVal("s7_err", 24'(SyncErr), 24'd1);
        checkVal("s7_slot", 24'(Slot), 24'd1);

        // Sync without a sample returns to slot 0
        applyStimulus(1'b0, 1'b1, 3'd0, "sync_only");
        checkVal("sync_only_slot", 24'(Slot), 24'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux3w_1to8.md
DEMUX3W_1TO8 -- requirements
Module: demux3w_1to8

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, with ports named as follows.
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
REQ-002 SHALL provide the following data and control ports.
- D  input  3  time-division sample word.
- Valid  input  1  D carries a sample this cycle.
- Sync  input  1  when high, the current cycle starts a new frame at slot 0.
- R, S, T, U, V, W, X, Y  output  3 each  frame lanes 0..7, registered.
- Slot  output  3  index of the slot the next accepted sample fills.
- FrameDone  output  1  one-cycle pulse on the edge where the lanes update.
- SyncErr  output  1  sticky short-frame flag.
REQ-003 SHALL define two constants, each with a fixed value: WIDTH = 3 (lane width) and NUM_SLOTS = 8.

Function
REQ-004 SHALL accept a sample on each rising edge where Valid = 1, and SHALL write D into staging register [Slot].
REQ-005 SHALL increment Slot by 1 on each accepted sample, wrapping from 7 to 0; with Valid = 0, Slot SHALL hold.
REQ-006 SHALL treat Valid = 1 and Sync = 1 as follows: the sample is written to staging slot 0, and Slot becomes 1.
REQ-007 SHALL treat Sync = 1 with Valid = 0 as follows: Slot becomes 0, and staging contents are don't-care thereafter.
REQ-008 SHALL set SyncErr if Sync = 1 arrives while Slot != 0; SyncErr SHALL clear only on reset.
REQ-009 SHALL, on the edge accepting the slot-7 sample, copy staging slots 0..6 plus the incoming D to lanes R..Y in the same edge, and SHALL pulse FrameDone high for exactly that following cycle.
REQ-010 SHALL hold lanes R..Y at their previous values between frame completions.
REQ-011 SHALL update no lane on a partial frame that is aborted by Sync.
REQ-012 SHALL have a latency of one clock from the slot-7 sample to the lanes changing; consecutive frames SHALL be back-to-back capable, with no idle cycles required.
REQ-013 SHALL, when Sync = 1 coincides with an accepted slot-7 sample (Slot = 7), treat Sync as taking priority: the sample goes to slot 0, there is no frame completion, and SyncErr is set.
REQ-014 SHALL make Slot reflect the post-edge value combinationally-free, i.e. driven directly from the counter register.

Reset
REQ-015 SHALL, while Resetn = 0, asynchronously force the following values: Slot = 0, all staging registers = 0, R..Y = 3'b000, FrameDone = 0, SyncErr = 0.
REQ-016 SHALL, on reset asserted mid-frame, discard the partial frame; the first sample accepted after release SHALL fill slot 0.
REQ-017 SHALL leave the first edge after Resetn deasserts as a normal operating edge.

Structure
REQ-018 SHALL place WIDTH and NUM_SLOTS in the shared lab constants package, and SHALL not redefine them locally.
REQ-019 SHALL use one sub-module, Decoder3to8, which converts Slot into an 8-bit one-hot write enable gated by Valid.
REQ-020 SHALL keep the staging registers, lane registers, counter, and flags in demux3w_1to8, with no combinational path from D to R..Y.

Verification
REQ-021 SHALL cover the following directed scenarios.
- Full frame: reset, then Valid for 8 cycles with D = 0..7 -> R=0, S=1, ..., Y=7 one edge after the 8th sample; FrameDone high for 1 cycle; Slot = 0.
- Gaps: the same 8 samples with Valid low on alternate cycles -> identical lane result; lanes unchanged until the 8th sample.
- Short frame: 3 samples (5,5,5), then Sync+Valid with D = 2 -> SyncErr = 1; no FrameDone; Slot = 1; the next 7 samples (3,...) complete a frame with R = 2.
- Back-to-back: 16 consecutive samples 0..15 mod 8 -> two FrameDone pulses exactly 8 cycles apart; lanes show 0..7 both times.
- Reset mid-frame: 4 samples, Resetn low for 1 cycle asynchronously between edges -> lanes all 0 immediately, Slot = 0; the next 8 samples fill R..Y in order.
- Sync at slot 7: 7 samples, then Sync+Valid with D = 6 -> no FrameDone; lanes unchanged; SyncErr = 1; Slot = 1.
